// File: rtl/db_tupu_ctrl.sv
// Deblocking top-PU info buffer controller: streams the previous LCU row's
// bottom-row PU info out of the 64x32 RAM, then writes the current LCU's bottom row back.
module db_tupu_ctrl #(
  parameter int ENT_NUM = 8,
  parameter int LCU_X_W = 3,
  parameter int ADR_W   = 6,
  parameter int DAT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [LCU_X_W-1:0] lcu_x_i,
  input  logic [7:0]         lcu_y_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               top_vld_o,
  output logic [2:0]         top_idx_o,
  output logic [DAT_W-1:0]   top_dat_o,
  input  logic               bot_vld_i,
  input  logic [2:0]         bot_idx_i,
  input  logic [DAT_W-1:0]   bot_dat_i,
  output logic               bot_rdy_o,
  output logic [ADR_W-1:0]   ram_adr_o,
  output logic               ram_cen_o,
  output logic               ram_wen_o,
  output logic [DAT_W-1:0]   ram_wdat_o,
  input  logic [DAT_W-1:0]   ram_rdat_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [2:0] LAST_IDX = 3'(ENT_NUM - 1);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [LCU_X_W-1:0] lcu_x_p0;
  logic               first_row_p0;
  logic [2:0]         rd_cnt;
  logic [2:0]         wr_cnt;
  logic               start_acc;
  logic               bot_acc;
  logic               top_vld_p1;
  logic [2:0]         top_idx_p1;

  assign start_acc = (state == IDLE) && start_i;
  assign bot_acc   = (state == STORE) && bot_vld_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = LOAD;
      LOAD:    if (rd_cnt == LAST_IDX) state_nxt = STORE;
      STORE:   if (bot_acc && (wr_cnt == LAST_IDX)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      first_row_p0 <= 1'b0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      top_vld_p1   <= 1'b0;
      top_idx_p1   <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        first_row_p0 <= (lcu_y_i == 8'd0);
        rd_cnt       <= '0;
        wr_cnt       <= '0;
      end else begin
        if (state == LOAD) rd_cnt <= rd_cnt + 3'd1;
        if (bot_acc)       wr_cnt <= wr_cnt + 3'd1;
      end
      // p0 -> p1: top entry tracks the read issued one cycle earlier
      top_vld_p1 <= (state == LOAD);
      top_idx_p1 <= rd_cnt;
    end
  end

  // Column index is data only; every use is qualified by the FSM state
  always_ff @(posedge clk) begin
    if (start_acc) lcu_x_p0 <= lcu_x_i;
  end

  always_comb begin
    ram_cen_o  = 1'b1;
    ram_wen_o  = 1'b1;
    ram_adr_o  = '0;
    ram_wdat_o = '0;
    if ((state == LOAD) && !first_row_p0) begin
      ram_cen_o = 1'b0;
      ram_adr_o = ADR_W'({lcu_x_p0, rd_cnt});
    end else if (bot_acc) begin
      ram_cen_o  = 1'b0;
      ram_wen_o  = 1'b0;
      ram_adr_o  = ADR_W'({lcu_x_p0, bot_idx_i});
      ram_wdat_o = bot_dat_i;
    end
  end

  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);
  assign bot_rdy_o = (state == STORE);
  assign top_vld_o = top_vld_p1;
  assign top_idx_o = top_idx_p1;
  // The first LCU row has no row above it, so its top entries read as zero
  assign top_dat_o = (top_vld_p1 && !first_row_p0) ? ram_rdat_i : '0;

endmodule

// File: tb/tb_db_tupu_ctrl.sv
// Directed bench for db_tupu_ctrl with a behavioural single-port RAM
// (one-cycle read latency) attached to the controller's RAM port.
module tb_db_tupu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  lcu_x_i;
  logic [7:0]  lcu_y_i;
  logic        busy_o, done_o, top_vld_o, bot_rdy_o;
  logic [2:0]  top_idx_o;
  logic [31:0] top_dat_o;
  logic        bot_vld_i;
  logic [2:0]  bot_idx_i;
  logic [31:0] bot_dat_i;
  logic [5:0]  ram_adr_o;
  logic        ram_cen_o, ram_wen_o;
  logic [31:0] ram_wdat_o;
  logic [31:0] ram_rdat_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];
  logic [31:0] exp_top  [0:7];
  logic [2:0]  beat_idx [0:7];
  logic [31:0] beat_dat [0:7];

  db_tupu_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .lcu_x_i(lcu_x_i), .lcu_y_i(lcu_y_i),
    .busy_o(busy_o), .done_o(done_o), .top_vld_o(top_vld_o), .top_idx_o(top_idx_o),
    .top_dat_o(top_dat_o), .bot_vld_i(bot_vld_i), .bot_idx_i(bot_idx_i),
    .bot_dat_i(bot_dat_i), .bot_rdy_o(bot_rdy_o), .ram_adr_o(ram_adr_o),
    .ram_cen_o(ram_cen_o), .ram_wen_o(ram_wen_o), .ram_wdat_o(ram_wdat_o),
    .ram_rdat_i(ram_rdat_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_cen_o) begin
      if (!ram_wen_o) mem[ram_adr_o] <= ram_wdat_o;
      else            ram_rdat_i <= mem[ram_adr_o];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic set_beats(input logic [31:0] base, input bit rev);
    for (int j = 0; j < 8; j++) begin
      beat_idx[j] = rev ? 3'(7 - j) : 3'(j);
      beat_dat[j] = base + 32'(beat_idx[j]);
    end
  endtask

  task automatic set_exp(input logic [31:0] base);
    for (int k = 0; k < 8; k++) exp_top[k] = base + 32'(k);
  endtask

  // Called at a negedge; returns at the negedge of the first LOAD cycle.
  task automatic do_start(input logic [2:0] x, input logic [7:0] y);
    start_i = 1'b1; lcu_x_i = x; lcu_y_i = y;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Covers LOAD cycles T+1..T+8 and returns inside cycle T+9 (first STORE cycle).
  task automatic run_load(input logic [2:0] x, input bit first, input bit rej);
    logic [31:0] want;
    for (int i = 0; i < 9; i++) begin
      if (rej && i == 3) begin start_i = 1'b1; lcu_x_i = 3'd5; lcu_y_i = 8'd1; end
      else start_i = 1'b0;
      #1;
      if (i < 8) begin
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL load_busy i=%0d got %b want 1", i, busy_o); end
        checks++;
        if (first) begin
          if (ram_cen_o !== 1'b1) begin errors++; $display("FAIL load_first_cen i=%0d got %b want 1", i, ram_cen_o); end
        end else if (ram_cen_o !== 1'b0 || ram_wen_o !== 1'b1 || ram_adr_o !== {x, 3'(i)}) begin
          errors++;
          $display("FAIL load_rd i=%0d got cen=%b wen=%b adr=%0d want cen=0 wen=1 adr=%0d",
                   i, ram_cen_o, ram_wen_o, ram_adr_o, {x, 3'(i)});
        end
      end
      checks++;
      if (i == 0) begin
        if (top_vld_o !== 1'b0) begin errors++; $display("FAIL top_early got vld=%b want 0", top_vld_o); end
      end else begin
        want = first ? 32'h0 : exp_top[i-1];
        if (top_vld_o !== 1'b1 || top_idx_o !== 3'(i-1) || top_dat_o !== want) begin
          errors++;
          $display("FAIL top_out i=%0d got vld=%b idx=%0d dat=%h want vld=1 idx=%0d dat=%h",
                   i, top_vld_o, top_idx_o, top_dat_o, i-1, want);
        end
      end
      if (i < 8) @(negedge clk);
    end
    start_i = 1'b0;
  endtask

  // Starts inside the first STORE cycle; ends in the IDLE cycle after DONE.
  task automatic run_store(input logic [2:0] x, input bit throttle);
    for (int j = 0; j < 8; j++) begin
      if (throttle) begin
        bot_vld_i = 1'b0;
        #1;
        checks++;
        if (ram_cen_o !== 1'b1 || bot_rdy_o !== 1'b1) begin
          errors++; $display("FAIL store_gap j=%0d got cen=%b rdy=%b want cen=1 rdy=1", j, ram_cen_o, bot_rdy_o);
        end
        @(negedge clk);
      end
      bot_vld_i = 1'b1; bot_idx_i = beat_idx[j]; bot_dat_i = beat_dat[j];
      #1;
      checks++;
      if (bot_rdy_o !== 1'b1 || ram_cen_o !== 1'b0 || ram_wen_o !== 1'b0 ||
          ram_adr_o !== {x, beat_idx[j]} || ram_wdat_o !== beat_dat[j]) begin
        errors++;
        $display("FAIL store_wr j=%0d got rdy=%b cen=%b wen=%b adr=%0d wdat=%h want 1 0 0 adr=%0d wdat=%h",
                 j, bot_rdy_o, ram_cen_o, ram_wen_o, ram_adr_o, ram_wdat_o, {x, beat_idx[j]}, beat_dat[j]);
      end
      @(negedge clk);
    end
    // bot_vld_i kept high: must be ignored in DONE and IDLE
    #1;
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b1 || bot_rdy_o !== 1'b0 || ram_cen_o !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle got done=%b busy=%b rdy=%b cen=%b want 1 1 0 1", done_o, busy_o, bot_rdy_o, ram_cen_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || ram_cen_o !== 1'b1) begin
      errors++;
      $display("FAIL after_done got done=%b busy=%b cen=%b want 0 0 1", done_o, busy_o, ram_cen_o);
    end
    bot_vld_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || top_vld_o !== 1'b0 || bot_rdy_o !== 1'b0 ||
        ram_cen_o !== 1'b1 || ram_wen_o !== 1'b1 || ram_adr_o !== 6'd0 ||
        ram_wdat_o !== 32'h0 || top_idx_o !== 3'd0 || top_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b tvld=%b rdy=%b cen=%b wen=%b adr=%0d wdat=%h tidx=%0d tdat=%h want 0 0 0 0 1 1 0 0 0 0",
               tag, busy_o, done_o, top_vld_o, bot_rdy_o, ram_cen_o, ram_wen_o, ram_adr_o,
               ram_wdat_o, top_idx_o, top_dat_o);
    end
  endtask

  task automatic test_reset;
    check_reset_outputs("reset_state");
  endtask

  task automatic test_first_row_store;
    set_beats(32'hA000_0000, 1'b0);
    do_start(3'd2, 8'd0);
    run_load(3'd2, 1'b1, 1'b0);
    run_store(3'd2, 1'b0);
  endtask

  task automatic test_store_then_load;
    set_exp(32'hA000_0000);
    do_start(3'd2, 8'd1);
    run_load(3'd2, 1'b0, 1'b0);
    run_store(3'd2, 1'b0);
  endtask

  task automatic test_throttled;
    set_beats(32'hB000_0000, 1'b0);
    do_start(3'd3, 8'd0);
    run_load(3'd3, 1'b1, 1'b0);
    run_store(3'd3, 1'b1);
  endtask

  task automatic test_busy_reject;
    bit extra_done;
    set_exp(32'hB000_0000);
    do_start(3'd3, 8'd1);
    run_load(3'd3, 1'b0, 1'b1);
    run_store(3'd3, 1'b0);
    extra_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (done_o !== 1'b0 || busy_o !== 1'b0) extra_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (extra_done) begin errors++; $display("FAIL busy_reject got a second run want none"); end
  endtask

  task automatic test_wrap;
    set_beats(32'hC000_0000, 1'b1);
    do_start(3'd7, 8'd0);
    run_load(3'd7, 1'b1, 1'b0);
    run_store(3'd7, 1'b0);
    set_exp(32'hC000_0000);
    do_start(3'd7, 8'd5);
    run_load(3'd7, 1'b0, 1'b0);
    run_store(3'd7, 1'b0);
  endtask

  task automatic test_reset_mid_store;
    set_beats(32'hE000_0000, 1'b0);
    do_start(3'd4, 8'd0);
    run_load(3'd4, 1'b1, 1'b0);
    run_store(3'd4, 1'b0);
    set_beats(32'hD000_0000, 1'b0);
    do_start(3'd4, 8'd0);
    run_load(3'd4, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) begin
      bot_vld_i = 1'b1; bot_idx_i = beat_idx[j]; bot_dat_i = beat_dat[j];
      @(negedge clk);
    end
    bot_vld_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("reset_mid_store");
    rst = 1'b0;
    @(negedge clk);
    // Entries 0..2 took the aborted run's data; 3..7 must be untouched
    for (int k = 0; k < 8; k++) exp_top[k] = (k < 3) ? 32'hD000_0000 + 32'(k) : 32'hE000_0000 + 32'(k);
    set_beats(32'hF000_0000, 1'b0);
    do_start(3'd4, 8'd2);
    run_load(3'd4, 1'b0, 1'b0);
    run_store(3'd4, 1'b0);
    set_exp(32'hF000_0000);
    do_start(3'd4, 8'd3);
    run_load(3'd4, 1'b0, 1'b0);
    run_store(3'd4, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; lcu_x_i = '0; lcu_y_i = '0;
    bot_vld_i = 1'b0; bot_idx_i = '0; bot_dat_i = '0;
    repeat (3) @(negedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_first_row_store;
    test_store_then_load;
    test_throttled;
    test_busy_reject;
    test_wrap;
    test_reset_mid_store;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
